barrel_spawner: RTL and testbench
=================================

Name: barrel_spawner

Overview:
- Parametrised successor to the horizontal barrel controller; owns a pool of SLOTS barrel slots and allocates a free slot per spawn.
- Spawns come from a key request (manual mode) or from a self-timed cadence (auto mode).
- Enforces a runtime-configurable cooldown and an active-barrel cap, and frees slots on rising edges of per-slot done.
- Sits between game-state logic (start/animation gating) and the per-slot barrel motion modules.

Parameters:
- SLOTS, 8, number of barrel slots (1..16).
- DELAY_W, 29, width of cooldown counter and delay_cfg.
- CNT_W, $clog2(SLOTS+1), width of count/cap fields (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  spawning allowed (driven by start_game && !animation).
- auto_mode  in  1  1 = spawn on cooldown expiry without a request.
- spawn_req  in  1  one-cycle manual spawn request.
- clear  in  1  level reset: drop all barrels, e.g. at level end.
- done  in  SLOTS  per-slot finished flag (level); a rising edge frees the slot.
- delay_cfg  in  DELAY_W  cooldown length in cycles; 0 treated as 1.
- max_active  in  CNT_W  active-barrel cap; values > SLOTS treated as SLOTS; 0 blocks all spawns.
- barrel  out  SLOTS  slot-active mask.
- spawn_pulse  out  SLOTS  one-hot, one-cycle pulse on the slot just allocated.
- active_count  out  CNT_W  popcount of barrel.
- busy  out  1  high while in COOLDOWN.
- rejected  out  1  one-cycle pulse: request arrived in IDLE with no capacity.

Behaviour:
- Reset/clear:
  - rst zeroes every register: barrel, spawn_pulse, rejected, pending, counter, done_prev; state = IDLE. All outputs read 0 the cycle after rst.
  - clear has the same effect as rst, except done_prev keeps sampling done. clear beats every spawn and free in the same cycle.
- Free logic:
  - done_rise = done & ~done_prev; done_prev <= done every cycle.
  - Freeing acts in all states, including when enable = 0.
- Capacity:
  - free = ~barrel | done_rise.
  - cap_ok = (free != 0) && (popcount(barrel & ~done_rise) < eff_max), where eff_max = min(max_active, SLOTS).
- Trigger:
  - trig = spawn_req || pending || auto_mode.
- States: IDLE, COOLDOWN.
- IDLE with enable && trig:
  - If cap_ok: accept. Slot = lowest index set in free. barrel <= (barrel & ~done_rise) | onehot. spawn_pulse <= onehot. pending <= 0. Latch D = max(delay_cfg, 1). counter <= 0. Go to COOLDOWN.
  - Else: if spawn_req || pending, set rejected <= 1 and pending <= 0. Auto-only triggers never assert rejected. Stay IDLE.
- COOLDOWN:
  - counter increments each cycle; go to IDLE when counter == D-1.
  - The next acceptance is no earlier than t + D + 1, where t is the accept cycle (minimum spawn spacing D+1 cycles).
  - spawn_req during COOLDOWN sets pending (one-deep; further requests are merged).
- enable = 0:
  - No acceptance; pending cleared; the cooldown still runs to completion.
  - Barrels already in flight stay in flight and are freed by done.
- Timing:
  - barrel, spawn_pulse and rejected are registered; they change one cycle after the triggering input.
  - active_count = popcount(barrel register), combinational from barrel.
  - busy = (state == COOLDOWN).
- Simultaneous events:
  - A done_rise and an accept in the same cycle: the freed slot is eligible and may be reallocated immediately; the mask never shows it doubly set.
- Invariants:
  - spawn_pulse is zero or one-hot, and every spawn_pulse bit is also set in barrel the same cycle.
  - A slot is never allocated while its barrel bit is set and not being freed.
  - active_count <= eff_max after any acceptance.

Test Plan:
- SLOTS=4, delay_cfg=3, manual; spawn_req at cycle 10 -> spawn_pulse=0001 and barrel=0001 at cycle 11; busy high cycles 11..13; a request at cycle 14 is accepted (barrel=0011 at 15).
- barrel=1111, spawn_req in IDLE -> rejected pulse one cycle later, barrel unchanged; done[2] rising with spawn_req in the same cycle -> slot 2 reallocated, barrel stays 1111, spawn_pulse=0100.
- max_active=2, auto_mode=1, delay_cfg=1 -> barrel goes 0001, 0011 two cycles apart, then holds at 0011 with no rejected pulses; done[0] rises -> slot 0 respawned on the next IDLE cycle.
- spawn_req twice during COOLDOWN -> exactly one spawn when IDLE is re-entered (pending merged), barrel gains one bit only.
- clear while barrel=0111 and in COOLDOWN -> next cycle barrel=0, busy=0, pending=0; a done level still high afterwards produces no spurious free.
- enable=0 with spawn_req and auto_mode pulsed -> no spawn_pulse; done[1] rise still clears barrel[1]; rst mid-COOLDOWN -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/barrel_spawner.sv
// rtl/barrel_spawner.sv - barrel slot pool allocator with cooldown, active cap and done-driven frees
module barrel_spawner #(
  parameter int SLOTS = 8,
  parameter int DELAY_W = 29,
  localparam int CNT_W = $clog2(SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               auto_mode,
  input  logic               spawn_req,
  input  logic               clear,
  input  logic [SLOTS-1:0]   done,
  input  logic [DELAY_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0]   max_active,
  output logic [SLOTS-1:0]   barrel,
  output logic [SLOTS-1:0]   spawn_pulse,
  output logic [CNT_W-1:0]   active_count,
  output logic               busy,
  output logic               rejected
);

  typedef enum logic {IDLE, COOLDOWN} state_t;

  state_t             state;
  logic               pending;
  logic [DELAY_W-1:0] counter;
  logic [DELAY_W-1:0] delay_d;
  logic [SLOTS-1:0]   done_prev;

  logic [SLOTS-1:0] done_rise;
  logic [SLOTS-1:0] kept;
  logic [SLOTS-1:0] free;
  logic [SLOTS-1:0] onehot;
  logic [CNT_W-1:0] eff_max;
  logic             cap_ok;
  logic             trig;

  function automatic logic [CNT_W-1:0] popcount(input logic [SLOTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < SLOTS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // A slot finishing this cycle counts as free, so it can be reused immediately.
  always_comb begin
    done_rise = done & ~done_prev;
    kept      = barrel & ~done_rise;
    free      = ~barrel | done_rise;
    eff_max   = (max_active > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : max_active;
    cap_ok    = (free != '0) && (popcount(kept) < eff_max);
    trig      = spawn_req || pending || auto_mode;
    onehot    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state       <= IDLE;
      barrel      <= '0;
      spawn_pulse <= '0;
      rejected    <= 1'b0;
      pending     <= 1'b0;
      counter     <= '0;
      delay_d     <= '0;
      // clear keeps tracking done so a level still high afterwards is not seen as a new rise
      done_prev   <= rst ? '0 : done;
    end else begin
      done_prev   <= done;
      barrel      <= kept;
      spawn_pulse <= '0;
      rejected    <= 1'b0;
      case (state)
        IDLE: begin
          if (!enable) begin
            pending <= 1'b0;
          end else if (trig) begin
            if (cap_ok) begin
              barrel      <= kept | onehot;
              spawn_pulse <= onehot;
              pending     <= 1'b0;
              delay_d     <= (delay_cfg == '0) ? DELAY_W'(1) : delay_cfg;
              counter     <= '0;
              state       <= COOLDOWN;
            end else if (spawn_req || pending) begin
              rejected <= 1'b1;
              pending  <= 1'b0;
            end
          end
        end
        COOLDOWN: begin
          if (!enable) pending <= 1'b0;
          else if (spawn_req) pending <= 1'b1;
          if (counter == delay_d - DELAY_W'(1)) begin
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + DELAY_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active_count = popcount(barrel);
  assign busy         = (state == COOLDOWN);

endmodule

// File: tb/tb_barrel_spawner.sv
// tb/tb_barrel_spawner.sv - directed bench for barrel_spawner with a cycle-level reference model
module tb_barrel_spawner;
  localparam int SLOTS = 4;
  localparam int DELAY_W = 8;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst, enable, auto_mode, spawn_req, clear;
  logic [SLOTS-1:0]   done;
  logic [DELAY_W-1:0] delay_cfg;
  logic [CNT_W-1:0]   max_active;
  logic [SLOTS-1:0]   barrel, spawn_pulse;
  logic [CNT_W-1:0]   active_count;
  logic               busy, rejected;

  int total = 0;
  int bad = 0;
  bit checking = 0;

  barrel_spawner #(.SLOTS(SLOTS), .DELAY_W(DELAY_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode),
    .spawn_req(spawn_req), .clear(clear), .done(done), .delay_cfg(delay_cfg),
    .max_active(max_active), .barrel(barrel), .spawn_pulse(spawn_pulse),
    .active_count(active_count), .busy(busy), .rejected(rejected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a set of live slots plus the last cycle still inside the cooldown window.
  logic [SLOTS-1:0] m_barrel = '0, m_pulse = '0, m_dprev = '0;
  bit m_rej = 0, m_pending = 0, m_busy = 0;
  int cyc = 0;
  int busy_until = -1;

  always @(posedge clk) begin
    logic [SLOTS-1:0] rise, live;
    int lim, slot, d;
    if (rst || clear) begin
      m_barrel = '0; m_pulse = '0; m_rej = 0; m_pending = 0; busy_until = -1;
      m_dprev = rst ? '0 : done;
    end else begin
      rise = done & ~m_dprev;
      m_dprev = done;
      live = m_barrel & ~rise;
      m_pulse = '0;
      m_rej = 0;
      if (!enable) begin
        m_pending = 0;
      end else if (cyc > busy_until) begin
        if (spawn_req || m_pending || auto_mode) begin
          lim = (int'(max_active) > SLOTS) ? SLOTS : int'(max_active);
          slot = -1;
          for (int i = 0; i < SLOTS; i++) if (!live[i]) begin slot = i; break; end
          if (slot >= 0 && $countones(live) < lim) begin
            live[slot] = 1'b1;
            m_pulse[slot] = 1'b1;
            m_pending = 0;
            d = (delay_cfg == 0) ? 1 : int'(delay_cfg);
            busy_until = cyc + d;
          end else if (spawn_req || m_pending) begin
            m_rej = 1;
            m_pending = 0;
          end
        end
      end else if (spawn_req) begin
        m_pending = 1;
      end
      m_barrel = live;
    end
    m_busy = (cyc + 1 <= busy_until);
    cyc++;
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("barrel", 32'(barrel), 32'(m_barrel));
      chk("spawn_pulse", 32'(spawn_pulse), 32'(m_pulse));
      chk("rejected", 32'(rejected), 32'(m_rej));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("active_count", 32'(active_count), 32'($countones(m_barrel)));
      chk("pulse_in_barrel", 32'(spawn_pulse & ~barrel), 32'd0);
      chk("pulse_onehot", 32'($countones(spawn_pulse) <= 1), 32'd1);
    end
  end

  task automatic spawn_and_wait();
    spawn_req = 1; tick(); spawn_req = 0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1; enable = 1; auto_mode = 0; spawn_req = 0; clear = 0;
    done = '0; delay_cfg = 3; max_active = 4;
    tick(); checking = 1; tick(); rst = 0;
    chk("rst_barrel", 32'(barrel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(active_count), 0);
    repeat (3) tick();

    // manual spawn, cooldown of 3, next request accepted right after
    spawn_req = 1; tick(); spawn_req = 0;
    chk("a_pulse", 32'(spawn_pulse), 32'b0001);
    chk("a_barrel", 32'(barrel), 32'b0001);
    chk("a_busy1", 32'(busy), 1);
    tick(); tick();
    chk("a_busy3", 32'(busy), 1);
    tick();
    chk("a_idle", 32'(busy), 0);
    spawn_req = 1; tick(); spawn_req = 0;
    chk("a_barrel2", 32'(barrel), 32'b0011);
    repeat (4) tick();

    // full pool: reject, then reuse of a slot freed in the same cycle (cap clamped to SLOTS)
    max_active = 7;
    spawn_and_wait();
    spawn_and_wait();
    chk("b_full", 32'(barrel), 32'b1111);
    spawn_req = 1; tick(); spawn_req = 0;
    chk("b_rej", 32'(rejected), 1);
    chk("b_rej_barrel", 32'(barrel), 32'b1111);
    tick();
    chk("b_rej_pulse_end", 32'(rejected), 0);
    done = 4'b0100; spawn_req = 1; tick(); spawn_req = 0;
    chk("b_reuse_barrel", 32'(barrel), 32'b1111);
    chk("b_reuse_pulse", 32'(spawn_pulse), 32'b0100);
    repeat (4) tick();
    done = '0; tick();

    // auto mode with cap of 2 and delay 1
    clear = 1; tick(); clear = 0;
    chk("c_clear", 32'(barrel), 0);
    max_active = 2; delay_cfg = 1; auto_mode = 1;
    tick();
    chk("c_first", 32'(barrel), 32'b0001);
    tick(); tick();
    chk("c_second", 32'(barrel), 32'b0011);
    chk("c_second_pulse", 32'(spawn_pulse), 32'b0010);
    repeat (4) tick();
    chk("c_hold", 32'(barrel), 32'b0011);
    chk("c_norej", 32'(rejected), 0);
    done = 4'b0001; tick();
    chk("c_respawn", 32'(spawn_pulse), 32'b0001);
    auto_mode = 0; done = '0;
    repeat (3) tick();

    // two requests during cooldown merge into one pending spawn
    clear = 1; tick(); clear = 0;
    max_active = 4; delay_cfg = 3;
    spawn_req = 1; tick(); spawn_req = 0;
    spawn_req = 1; tick(); spawn_req = 0;
    tick();
    spawn_req = 1; tick(); spawn_req = 0;
    tick();
    chk("d_pending_spawn", 32'(spawn_pulse), 32'b0010);
    chk("d_barrel", 32'(barrel), 32'b0011);
    repeat (5) tick();
    chk("d_one_bit", 32'(barrel), 32'b0011);

    // clear during cooldown with pending set and a done level held high
    spawn_req = 1; tick(); spawn_req = 0;
    chk("e_barrel", 32'(barrel), 32'b0111);
    spawn_req = 1; tick(); spawn_req = 0;
    clear = 1; done = 4'b0001; tick(); clear = 0;
    chk("e_clear_barrel", 32'(barrel), 0);
    chk("e_clear_busy", 32'(busy), 0);
    tick();
    chk("e_no_pending", 32'(spawn_pulse), 0);
    spawn_req = 1; tick(); spawn_req = 0;
    chk("e_slot0", 32'(barrel), 32'b0001);
    repeat (4) tick();
    chk("e_no_free", 32'(barrel), 32'b0001);
    done = '0; tick();

    // enable low blocks spawns but frees still act; rst mid-cooldown
    spawn_and_wait();
    enable = 0; spawn_req = 1; auto_mode = 1; tick();
    spawn_req = 0; auto_mode = 0;
    chk("f_no_spawn", 32'(spawn_pulse), 0);
    chk("f_barrel", 32'(barrel), 32'b0011);
    done = 4'b0010; tick();
    chk("f_free", 32'(barrel), 32'b0001);
    done = '0; enable = 1; tick();
    spawn_req = 1; tick(); spawn_req = 0;
    tick();
    rst = 1; tick(); rst = 0;
    chk("f_rst_barrel", 32'(barrel), 0);
    chk("f_rst_busy", 32'(busy), 0);
    chk("f_rst_count", 32'(active_count), 0);
    chk("f_rst_pulse", 32'(spawn_pulse), 0);
    chk("f_rst_rej", 32'(rejected), 0);
    tick();

    // delay_cfg of 0 behaves as 1: spawns two cycles apart
    delay_cfg = 0; spawn_req = 1; tick();
    chk("g_first", 32'(spawn_pulse), 32'b0001);
    tick();
    chk("g_gap", 32'(spawn_pulse), 0);
    tick();
    chk("g_second", 32'(spawn_pulse), 32'b0010);
    spawn_req = 0;
    repeat (3) tick();

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
